// File: rtl/neuron_pkg.sv
// Shared FP32 field widths, special-value constants and the neuron MAC FSM state encoding.
package neuron_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_NEG_INF = 32'hFF80_0000;
    localparam logic [FP_W-1:0] FP_ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/fp32_add.sv
// Combinational FP32 adder: truncating rounding, denormal flush-to-zero, canonical NaN, +0 for exact zero.
module fp32_add
    import neuron_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y
);

    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              swap;
    logic [FP_W-1:0]   big, sml;
    logic [26:0]       big_ext, sml_ext, sml_al;
    logic [53:0]       sml_sh;
    logic [EXP_W-1:0]  exp_diff;
    logic [4:0]        shamt, lead;
    logic [27:0]       sum, norm;
    logic [MAN_W-1:0]  man_res;
    logic signed [9:0] exp_res;

    always_comb begin
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = !(|a[30:23]);
        b_zero = !(|b[30:23]);

        swap     = b[30:0] > a[30:0];
        big      = swap ? b : a;
        sml      = swap ? a : b;
        big_ext  = {1'b1, big[22:0], 3'b000};
        sml_ext  = {1'b1, sml[22:0], 3'b000};
        exp_diff = big[30:23] - sml[30:23];
        shamt    = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];

        // Bit 0 is a dedicated sticky position so truncation of the exact sum stays correct
        sml_sh = {sml_ext, 27'd0} >> shamt;
        sml_al = {sml_sh[53:28], sml_sh[27] | (|sml_sh[26:0])};
        sum    = (big[31] == sml[31]) ? ({1'b0, big_ext} + {1'b0, sml_al})
                                      : ({1'b0, big_ext} - {1'b0, sml_al});

        lead = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (sum[i]) lead = 5'(i);
        end
        norm    = sum << (5'd27 - lead);
        man_res = 23'(norm >> 4);
        exp_res = $signed({2'b00, big[30:23]}) + $signed({5'd0, lead}) - 10'sd26;

        y = FP_ZERO;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) y = FP_QNAN;
        else if (a_inf)                 y = a;
        else if (b_inf)                 y = b;
        else if (a_zero && b_zero)      y = FP_ZERO;
        else if (a_zero)                y = b;
        else if (b_zero)                y = a;
        else if (sum == 28'd0)          y = FP_ZERO;
        else if (exp_res >= 10'sd255)   y = big[31] ? FP_NEG_INF : FP_POS_INF;
        else if (exp_res <= 10'sd0)     y = {big[31], 31'd0};
        else                            y = {big[31], exp_res[7:0], man_res};
    end

endmodule

// File: rtl/neuron_z_mac.sv
// Single neuron pre-activation Z = bias + sum(x_i * w_i) in FP32, one pair per cycle.
// Define NEURON_Z_RELU_EN to clamp negative results to +0 (NaN still passes through).
module neuron_z_mac
    import neuron_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [FP_W-1:0] bias,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] neuron_input,
    input  logic [FP_W-1:0] weight,
    output logic            busy,
    output logic            out_valid,
    output logic [FP_W-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP_W-1:0]   acc_q, acc_d, prod_q, prod_d, result_q, result_d;
    logic              prod_vld_q, prod_vld_d, out_valid_q, out_valid_d;
    logic              accept, last_pair;
    logic [FP_W-1:0]   add_y, mul_y, z_final;

    logic              x_nan, w_nan, x_inf, w_inf, x_zero, w_zero, mul_sign;
    logic [47:0]       mul_full;
    logic [MAN_W-1:0]  mul_man;
    logic signed [9:0] mul_exp;

    fp32_add u_add (
        .a (acc_q),
        .b (prod_q),
        .y (add_y)
    );

    always_comb begin
        x_nan    = (&neuron_input[30:23]) && (|neuron_input[22:0]);
        w_nan    = (&weight[30:23]) && (|weight[22:0]);
        x_inf    = (&neuron_input[30:23]) && !(|neuron_input[22:0]);
        w_inf    = (&weight[30:23]) && !(|weight[22:0]);
        x_zero   = !(|neuron_input[30:23]);
        w_zero   = !(|weight[30:23]);
        mul_sign = neuron_input[31] ^ weight[31];
        mul_full = 48'({1'b1, neuron_input[22:0]}) * 48'({1'b1, weight[22:0]});
        mul_man  = mul_full[47] ? 23'(mul_full >> 24) : 23'(mul_full >> 23);
        mul_exp  = $signed({2'b00, neuron_input[30:23]}) + $signed({2'b00, weight[30:23]})
                 - 10'sd127 + $signed({9'd0, mul_full[47]});

        mul_y = {mul_sign, 31'd0};
        if (x_nan || w_nan || (x_inf && w_zero) || (w_inf && x_zero)) mul_y = FP_QNAN;
        else if (x_inf || w_inf)       mul_y = {mul_sign, 8'hFF, 23'd0};
        else if (x_zero || w_zero)     mul_y = {mul_sign, 31'd0};
        else if (mul_exp >= 10'sd255)  mul_y = {mul_sign, 8'hFF, 23'd0};
        else if (mul_exp <= 10'sd0)    mul_y = {mul_sign, 31'd0};
        else                           mul_y = {mul_sign, mul_exp[7:0], mul_man};
    end

`ifdef NEURON_Z_RELU_EN
    assign z_final = (acc_q[30:23] == 8'hFF && |acc_q[22:0]) ? FP_QNAN :
                     acc_q[31] ? FP_ZERO : acc_q;
`else
    assign z_final = acc_q;
`endif

    assign in_ready  = (state_q == ST_ACCUM);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign accept    = in_valid && in_ready;
    assign last_pair = (cnt_q == CNT_W'(NUM_INPUTS - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        result_d    = result_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the result pulse is dropped
                if (start && !out_valid_q) begin
                    state_d = ST_ACCUM;
                    acc_d   = bias;
                    cnt_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (prod_vld_q) acc_d = add_y;
                if (accept) begin
                    prod_d     = mul_y;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (last_pair) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (prod_vld_q) acc_d = add_y;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d    = z_final;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= FP_ZERO;
            prod_q      <= FP_ZERO;
            prod_vld_q  <= 1'b0;
            result_q    <= FP_ZERO;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_z_mac.sv
// Self-checking bench for neuron_z_mac: directed corner cases plus randomized neurons vs a real-arithmetic model.
module tb_neuron_z_mac;

    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset_n, start, in_valid, in_ready, busy, out_valid;
    logic [31:0] bias, neuron_input, weight, result;
    logic [31:0] px[N];
    logic [31:0] pw[N];
    int          cmp_cnt = 0;
    int          err_cnt = 0;

    always #5 clock = ~clock;

    neuron_z_mac #(.NUM_INPUTS(N)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .bias         (bias),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .neuron_input (neuron_input),
        .weight       (weight),
        .busy         (busy),
        .out_valid    (out_valid),
        .result       (result)
    );

    // Reference: exact arithmetic in double, then truncate toward zero to FP32
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] model_z(input logic [31:0] b);
        logic [31:0] acc;
        acc = b;
        for (int i = 0; i < N; i++)
            acc = r2f(f2r(acc) + f2r(r2f(f2r(px[i]) * f2r(pw[i]))));
`ifdef NEURON_Z_RELU_EN
        if (acc[31]) acc = 32'h0;
`endif
        return acc;
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(130, 124)), 23'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one evaluation; optionally pulses start mid-ACCUM or in the out_valid cycle
    task automatic run_neuron(input logic [31:0] b, input int gap, input int busy_at, input bit poke,
                              output logic [31:0] res, output int lat, output int pulses,
                              output logic busy_after);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = $urandom;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) tick();
            in_valid     = 1'b1;
            neuron_input = px[i];
            weight       = pw[i];
            if (i == busy_at) begin
                start = 1'b1;
                bias  = 32'h42C8_0000;
            end
            tick();
            in_valid     = 1'b0;
            start        = 1'b0;
            neuron_input = $urandom;
            weight       = $urandom;
        end
        lat        = -1;
        pulses     = 0;
        res        = 'x;
        busy_after = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (poke && lat > 0 && c == lat + 1) begin
                busy_after = busy;
                start      = 1'b0;
            end
            if (out_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    res = result;
                    if (poke) begin
                        start = 1'b1;
                        bias  = 32'h3F80_0000;
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        bias = '0; neuron_input = '0; weight = '0;
        tick(); tick();
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        cmp_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h expected 00000000", result); end
        reset_n = 1'b1;
        tick();
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        logic [31:0] res; int lat, pulses; logic ba;
        px = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        pw = '{32'h3FC0_0000, 32'h0, 32'h0, 32'h0};
        run_neuron(32'h3F80_0000, 0, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== 32'h4080_0000) begin err_cnt++; $display("FAIL basic_result: got %h expected 40800000", res); end
        cmp_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
        cmp_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        cmp_cnt++; if (result !== 32'h4080_0000) begin err_cnt++; $display("FAIL basic_hold: got %h expected 40800000", result); end
    endtask

    task automatic test_relu();
        logic [31:0] res, expv; int lat, pulses; logic ba;
        for (int i = 0; i < N; i++) begin px[i] = 32'h3F80_0000; pw[i] = 32'h3F80_0000; end
`ifdef NEURON_Z_RELU_EN
        expv = 32'h0000_0000;
`else
        expv = 32'hC0C0_0000;
`endif
        run_neuron(32'hC120_0000, 0, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL relu_result: got %h expected %h", res, expv); end
    endtask

    task automatic test_gaps();
        logic [31:0] res; int lat, pulses; logic ba;
        px = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        pw = '{32'h3FC0_0000, 32'h0, 32'h0, 32'h0};
        run_neuron(32'h3F80_0000, 3, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== 32'h4080_0000) begin err_cnt++; $display("FAIL gaps_result: got %h expected 40800000", res); end
        cmp_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL gaps_latency: got %0d expected 2", lat); end
        cmp_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL gaps_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_overflow_nan();
        logic [31:0] res; int lat, pulses; logic ba;
        px = '{32'h7F00_0000, 32'h0, 32'h0, 32'h0};
        pw = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        run_neuron(32'h0, 0, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== 32'h7F80_0000) begin err_cnt++; $display("FAIL overflow_result: got %h expected 7f800000", res); end
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        px[1] = 32'h7FC0_0001;
        run_neuron(rand_fp(), 1, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== 32'h7FC0_0000) begin err_cnt++; $display("FAIL nan_result: got %h expected 7fc00000", res); end
    endtask

    task automatic test_busy_start();
        logic [31:0] res, b, expv; int lat, pulses; logic ba;
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        b    = rand_fp();
        expv = model_z(b);
        run_neuron(b, 0, 1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL busy_start_result: got %h expected %h", res, expv); end
        cmp_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL busy_start_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, b, expv; int lat, pulses, stray; logic ba;
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        start = 1'b1; bias = rand_fp();
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; neuron_input = px[i]; weight = pw[i];
            tick();
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready); end
        cmp_cnt++; if (result !== 32'h0) begin err_cnt++; $display("FAIL rst_mid_result: got %h expected 00000000", result); end
        tick(); tick();
        reset_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid || busy) stray++;
        end
        cmp_cnt++; if (stray !== 0) begin err_cnt++; $display("FAIL rst_mid_stray: got %0d active cycles expected 0", stray); end
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        b    = rand_fp();
        expv = model_z(b);
        run_neuron(b, 0, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL rst_mid_fresh: got %h expected %h", res, expv); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, b, expv; int lat, pulses; logic ba;
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        b    = rand_fp();
        expv = model_z(b);
        run_neuron(b, 0, -1, 1'b1, res, lat, pulses, ba);
        cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL b2b_first: got %h expected %h", res, expv); end
        cmp_cnt++; if (ba !== 1'b0) begin err_cnt++; $display("FAIL b2b_start_on_valid: busy got %b expected 0", ba); end
        cmp_cnt++; if (pulses !== 1) begin err_cnt++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
        for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
        b    = rand_fp();
        expv = model_z(b);
        run_neuron(b, 0, -1, 1'b0, res, lat, pulses, ba);
        cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL b2b_second: got %h expected %h", res, expv); end
    endtask

    task automatic test_random();
        logic [31:0] res, b, expv; int lat, pulses; logic ba;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < N; i++) begin px[i] = rand_fp(); pw[i] = rand_fp(); end
            b    = rand_fp();
            expv = model_z(b);
            run_neuron(b, $urandom_range(2, 0), -1, 1'b0, res, lat, pulses, ba);
            cmp_cnt++; if (res !== expv) begin err_cnt++; $display("FAIL random_result[%0d]: got %h expected %h", t, res, expv); end
            cmp_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL random_latency[%0d]: got %0d expected 2", t, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_gaps();
        test_overflow_nan();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/neuron_z_mac.md
NEURON_Z_MAC -- requirements
Module: neuron_z_mac

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of (input, weight) pairs accumulated per neuron; legal range 1..1024.
REQ-002 Parameter CNT_W, default $clog2(NUM_INPUTS+1), width of the internal pair counter.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  starts a neuron evaluation and is sampled only in IDLE.
REQ-006 bias  input  32  IEEE-754 single-precision bias, captured on an accepted start.
REQ-007 in_valid  input  1  neuron_input/weight pair is valid.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 neuron_input  input  32  FP32 activation.
REQ-010 weight  input  32  FP32 weight.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 out_valid  output  1  one-cycle pulse that marks result as new.
REQ-013 result  output  32  FP32 Z = bias + sum(neuron_input_i * weight_i).

Function
REQ-014 The FSM states SHALL be IDLE, ACCUM, DRAIN and DONE.
- IDLE->ACCUM on start.
- ACCUM->DRAIN on acceptance of pair NUM_INPUTS.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-015 A pair is accepted on any rising edge with in_valid && in_ready; in_ready SHALL equal (state==ACCUM).
REQ-016 Pipeline: an accepted pair's product SHALL be registered at the acceptance edge, then added into the accumulator at the next edge; throughput is one pair per cycle.
REQ-017 Gaps in in_valid SHALL stall the accumulation without corrupting it, and only accepted pairs are counted.
REQ-018 If the last pair is accepted at edge k, result SHALL update and out_valid SHALL be high in the cycle after edge k+2.
REQ-019 result SHALL hold its value until the next out_valid.
REQ-020 The accumulator SHALL be loaded with bias on the start edge, so the summation order is bias first, then pairs in acceptance order.
REQ-021 A start received outside IDLE SHALL be ignored, and a start received in the same cycle as the out_valid pulse SHALL also be ignored.
REQ-022 Arithmetic rules for both the multiply and the add:
- rounding is toward zero (truncation);
- denormal operands are flushed to signed zero;
- underflow gives signed zero;
- overflow gives signed infinity;
- any NaN operand, inf*0 or inf-inf gives 0x7FC00000;
- an exact-zero sum gives +0.

Reset
REQ-023 When reset_n is low, the block SHALL asynchronously force state=IDLE, counter=0, accumulator=0, product register=0, result=0, out_valid=0 and busy=0; in_ready then reads 0.
REQ-024 An assertion of reset during ACCUM or DRAIN SHALL abort the evaluation with no out_valid pulse, after which the next start begins a fresh evaluation.

Configuration
REQ-025 With NEURON_Z_RELU_EN defined, result SHALL be 0x00000000 whenever the final sum's sign bit is 1, except for NaN, which passes through as 0x7FC00000.
REQ-026 Without NEURON_Z_RELU_EN, result SHALL be the raw FP32 sum, and latency is identical in both builds.

Structure
REQ-027 The shared package neuron_pkg SHALL hold the FP32 field widths, the canonical NaN, ±infinity and zero constants, and the FSM state enumeration.
REQ-028 A single combinational sub-module fp32_add SHALL implement the addition; the multiply SHALL be inline in neuron_z_mac.

Verification
REQ-029 Basic sum, with NUM_INPUTS=4: bias=0x3F800000 (1.0); pairs (0x40000000, 0x3FC00000) (2.0*1.5), then three pairs (0, 0) -> result=0x40800000 (4.0) with a single out_valid pulse.
REQ-030 ReLU: bias=0xC1200000 (-10.0); four pairs of 1.0*1.0 -> result=0xC0C00000 (-6.0) without the macro, 0x00000000 with NEURON_Z_RELU_EN.
REQ-031 Input gaps: the same stimulus as REQ-029 with in_valid low for 3 cycles between each pair -> same result 0x40800000, and out_valid occurs 2 cycles after the last accepted pair.
REQ-032 Overflow and NaN:
- bias=0; pair (0x7F000000, 0x40000000) then three zero pairs -> result=0x7F800000;
- any pair with neuron_input 0x7FC00001 -> result=0x7FC00000.
REQ-033 Start while busy: a second start pulse in ACCUM with a different bias -> ignored, and the result is computed from the first bias.
REQ-034 Reset mid-operation: reset_n low after 2 accepted pairs -> all outputs 0 immediately, no out_valid; a new start then gives a correct fresh result.
